// File: rtl/multi_band_frequency_analyzer.sv
// Multi-band half-period analyzer: classifies every half-period of sample_data into programmable
// tick ranges and publishes per-window totals. Glitch filter via FREQUENCY_ANALYZER_GLITCH_FILTER_EN.
module multi_band_frequency_analyzer #(
   parameter int unsigned BANDS              = 4,
   parameter int unsigned COUNTER_WIDTH      = 32,
   parameter int unsigned CLOCK_FREQUENCY    = 50000000,
   parameter int unsigned DEFAULT_FREQUENCY0 = 9000,
   parameter int unsigned DEFAULT_FREQUENCY1 = 11000,
   parameter int unsigned DEFAULT_DEVIATION  = 10,
   parameter int unsigned WINDOW_TICKS       = 50000000,
   parameter int unsigned FILTER_LENGTH      = 4
) (
   input  logic                     clock,
   input  logic                     clear,
   input  logic                     sample_data,
   input  logic                     enable,
   input  logic                     cfg_we,
   input  logic [2:0]               cfg_band,
   input  logic [COUNTER_WIDTH-1:0] cfg_low,
   input  logic [COUNTER_WIDTH-1:0] cfg_high,
   input  logic [3:0]               rd_band,
   output logic [COUNTER_WIDTH-1:0] rd_value,
   output logic                     result_valid,
   output logic [15:0]              window_count
);
   localparam int unsigned CW    = COUNTER_WIDTH;
   localparam int unsigned SLOTS = BANDS + 1;
   localparam int unsigned TW    = $clog2(WINDOW_TICKS);
   localparam int unsigned T0    = CLOCK_FREQUENCY / (2 * DEFAULT_FREQUENCY0);
   localparam int unsigned T1    = CLOCK_FREQUENCY / (2 * DEFAULT_FREQUENCY1);
   localparam int unsigned D0    = (T0 * DEFAULT_DEVIATION) / 100;
   localparam int unsigned D1    = (T1 * DEFAULT_DEVIATION) / 100;
   localparam logic [CW-1:0] LOW0    = CW'(T0 - D0);
   localparam logic [CW-1:0] HIGH0   = CW'(T0 + D0);
   localparam logic [CW-1:0] LOW1    = CW'(T1 - D1);
   localparam logic [CW-1:0] HIGH1   = CW'(T1 + D1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic          sync_meta, sync_data, clean_data, prev_data;
   logic [CW-1:0] cnt;
   logic          armed;
   logic [CW-1:0] band_low  [BANDS];
   logic [CW-1:0] band_high [BANDS];
   logic [CW-1:0] acc       [SLOTS];
   logic [CW-1:0] acc_next  [SLOTS];
   logic [CW-1:0] snap      [SLOTS];
   logic [TW-1:0] timer;
   logic          edge_c, classify_c, flush_c, tc_c, add_en_c;
   int            add_idx_c;
   logic [CW-1:0] rd_sel_c;

   function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
      logic [CW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CW] ? CNT_MAX : sum[CW-1:0];
   endfunction

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         sync_meta <= 1'b0;
         sync_data <= 1'b0;
         prev_data <= 1'b0;
      end else begin
         sync_meta <= sample_data;
         sync_data <= sync_meta;
         prev_data <= clean_data;
      end
   end

`ifdef FREQUENCY_ANALYZER_GLITCH_FILTER_EN
   localparam int unsigned FW = $clog2(FILTER_LENGTH + 1);
   logic [FW-1:0] stable_count;
   logic          filtered;

   // Follow the synchronized line only after it has held a new value for FILTER_LENGTH cycles.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         filtered     <= 1'b0;
         stable_count <= '0;
      end else if (sync_data == filtered) begin
         stable_count <= '0;
      end else if (stable_count == FW'(FILTER_LENGTH - 1)) begin
         filtered     <= sync_data;
         stable_count <= '0;
      end else begin
         stable_count <= stable_count + FW'(1);
      end
   end
   assign clean_data = filtered;
`else
   // FILTER_LENGTH only shapes the filter; without it the line passes straight through.
   assign clean_data = sync_data ^ 1'(FILTER_LENGTH * 0);
`endif

   assign edge_c     = clean_data != prev_data;
   assign classify_c = enable && edge_c && armed;
   assign flush_c    = !enable && armed && (cnt != '0);
   assign tc_c       = timer == TW'(WINDOW_TICKS - 1);

   // Lowest-index matching band wins; index BANDS is the unknown accumulator.
   always_comb begin
      add_en_c  = 1'b0;
      add_idx_c = int'(BANDS);
      if (classify_c) begin
         add_en_c = 1'b1;
         for (int i = int'(BANDS) - 1; i >= 0; i--)
            if (band_low[i] <= cnt && cnt <= band_high[i]) add_idx_c = i;
      end else if (flush_c) begin
         add_en_c = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(SLOTS); i++) begin
         acc_next[i] = acc[i];
         if (add_en_c && add_idx_c == i) acc_next[i] = sat_add(acc[i], cnt);
      end
   end

   always_comb begin
      rd_sel_c = '0;
      for (int i = 0; i < int'(SLOTS); i++)
         if (int'(rd_band) == i) rd_sel_c = snap[i];
   end

   // Half-period counter: the first edge after arming restarts without classifying.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         cnt   <= '0;
         armed <= 1'b0;
      end else if (!enable) begin
         cnt   <= '0;
         armed <= 1'b0;
      end else if (edge_c) begin
         cnt   <= CW'(1);
         armed <= 1'b1;
      end else if (armed && cnt != CNT_MAX) begin
         cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         for (int i = 0; i < int'(BANDS); i++) begin
            band_low[i]  <= (i == 0) ? LOW0  : ((i == 1) ? LOW1  : CNT_MAX);
            band_high[i] <= (i == 0) ? HIGH0 : ((i == 1) ? HIGH1 : '0);
         end
      end else if (cfg_we) begin
         for (int i = 0; i < int'(BANDS); i++) begin
            if (int'(cfg_band) == i) begin
               band_low[i]  <= cfg_low;
               band_high[i] <= cfg_high;
            end
         end
      end
   end

   // Window close: snapshot includes any update landing on the terminal cycle.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         for (int i = 0; i < int'(SLOTS); i++) begin
            acc[i]  <= '0;
            snap[i] <= '0;
         end
         timer        <= '0;
         window_count <= '0;
         result_valid <= 1'b0;
         rd_value     <= '0;
      end else begin
         for (int i = 0; i < int'(SLOTS); i++) begin
            acc[i] <= tc_c ? '0 : acc_next[i];
            if (tc_c) snap[i] <= acc_next[i];
         end
         timer        <= tc_c ? '0 : timer + TW'(1);
         window_count <= tc_c ? window_count + 16'd1 : window_count;
         result_valid <= tc_c;
         rd_value     <= rd_sel_c;
      end
   end
endmodule

// File: tb/tb_multi_band_frequency_analyzer.sv
// Directed bench for multi_band_frequency_analyzer: one 300-tick instance for band logic and a
// narrow 8-bit, 1000-tick instance for saturation and mid-stream reset.
module tb_multi_band_frequency_analyzer;
`ifdef FREQUENCY_ANALYZER_GLITCH_FILTER_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 3;
`endif

   logic        clock = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          pulses_a = 0;
   int          pulses_b = 0;

   logic        clear_a, en_a, cfg_we_a, valid_a;
   logic [2:0]  cfg_band_a;
   logic [31:0] cfg_low_a, cfg_high_a, rd_value_a;
   logic [3:0]  rd_band_a;
   logic [15:0] wcount_a;
   logic        sample_a;
   logic        wave_a = 1'b0, manual_a = 1'b0, glitch_a = 1'b0;
   logic        wave_on_a = 1'b0, glitch_on_a = 1'b0;
   int          half_a = 15, phase_a = 0;

   logic        clear_b, en_b, cfg_we_b, valid_b;
   logic [2:0]  cfg_band_b;
   logic [7:0]  cfg_low_b, cfg_high_b, rd_value_b;
   logic [3:0]  rd_band_b;
   logic [15:0] wcount_b;
   logic        wave_b = 1'b0, wave_on_b = 1'b0;
   int          phase_b = 0;

   assign sample_a = wave_a ^ manual_a ^ glitch_a;

   always #5 clock = ~clock;

   multi_band_frequency_analyzer #(
      .BANDS(4), .COUNTER_WIDTH(32), .WINDOW_TICKS(300), .FILTER_LENGTH(4)
   ) dut_a (
      .clock(clock), .clear(clear_a), .sample_data(sample_a), .enable(en_a),
      .cfg_we(cfg_we_a), .cfg_band(cfg_band_a), .cfg_low(cfg_low_a), .cfg_high(cfg_high_a),
      .rd_band(rd_band_a), .rd_value(rd_value_a), .result_valid(valid_a), .window_count(wcount_a)
   );

   multi_band_frequency_analyzer #(
      .BANDS(4), .COUNTER_WIDTH(8), .WINDOW_TICKS(1000), .FILTER_LENGTH(4)
   ) dut_b (
      .clock(clock), .clear(clear_b), .sample_data(wave_b), .enable(en_b),
      .cfg_we(cfg_we_b), .cfg_band(cfg_band_b), .cfg_low(cfg_low_b), .cfg_high(cfg_high_b),
      .rd_band(rd_band_b), .rd_value(rd_value_b), .result_valid(valid_b), .window_count(wcount_b)
   );

   // Square wave with optional 2-cycle glitch at a fixed phase of each half-period.
   always @(negedge clock) begin
      if (!wave_on_a) begin
         phase_a  <= 0;
         glitch_a <= 1'b0;
      end else begin
         if (phase_a >= half_a - 1) begin
            phase_a <= 0;
            wave_a  <= ~wave_a;
         end else begin
            phase_a <= phase_a + 1;
         end
         glitch_a <= glitch_on_a && (phase_a == 20 || phase_a == 21);
      end
   end

   always @(negedge clock) begin
      if (wave_on_b) begin
         if (phase_b >= 99) begin
            phase_b <= 0;
            wave_b  <= ~wave_b;
         end else begin
            phase_b <= phase_b + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_pulse(input bit sel, output int cycles);
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while (!(sel ? valid_b : valid_a) && cycles < 3000);
      check(sel ? "pulse_seen_b" : "pulse_seen_a", sel ? valid_b : valid_a, 1);
      if (sel) pulses_b++;
      else pulses_a++;
   endtask

   task automatic cfg_a(input int band, input logic [31:0] lo, input logic [31:0] hi);
      cfg_band_a = 3'(band);
      cfg_low_a  = lo;
      cfg_high_a = hi;
      cfg_we_a   = 1'b1;
      step(1);
      cfg_we_a   = 1'b0;
   endtask

   task automatic read_a(input int band, output logic [31:0] v);
      rd_band_a = 4'(band);
      step(1);
      v = rd_value_a;
   endtask

   task automatic expect_a(input string tag, input int band, input logic [31:0] exp);
      logic [31:0] v;
      read_a(band, v);
      check(tag, v, exp);
   endtask

   task automatic expect_b(input string tag, input int band, input logic [7:0] exp);
      rd_band_b = 4'(band);
      step(1);
      check(tag, rd_value_b, exp);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      logic [31:0] v;
      clear_a = 1'b1; en_a = 1'b0; cfg_we_a = 1'b0; cfg_band_a = '0;
      cfg_low_a = '0; cfg_high_a = '0; rd_band_a = '0;
      clear_b = 1'b1; en_b = 1'b0; cfg_we_b = 1'b0; cfg_band_b = '0;
      cfg_low_b = '0; cfg_high_b = '0; rd_band_b = '0;
      step(3);
      check("a_reset_rd_value", rd_value_a, 0);
      check("a_reset_window_count", wcount_a, 0);
      check("a_reset_result_valid", valid_a, 0);
      clear_a = 1'b0;

      // Custom band 2 = 10..20 with half-period 15
      cfg_a(2, 10, 20);
      en_a = 1'b1; half_a = 15; wave_on_a = 1'b1;
      wait_pulse(0, cyc);
      wait_pulse(0, cyc);
      check("a_window_period", cyc, 300);
      check("a_window_count_2", wcount_a, 2);
      expect_a("custom_band2", 2, 300);
      check("result_valid_one_cycle", valid_a, 0);
      expect_a("custom_unknown", 4, 0);
      expect_a("custom_band0", 0, 0);
      expect_a("rd_band_6_zero", 6, 0);

      // Unmatched half-period 50; write to band 6 must be ignored
      cfg_a(6, 45, 55);
      half_a = 50;
      wait_pulse(0, cyc);
      wait_pulse(0, cyc);
      expect_a("unknown_total", 4, 300);
      expect_a("unknown_band2", 2, 0);
      expect_a("rd_band_5_zero", 5, 0);
      check("a_window_count_4", wcount_a, 4);

      // Band 0 overlaps band 2: lower index wins
      half_a = 15;
      cfg_a(0, 10, 20);
      wait_pulse(0, cyc);
      wait_pulse(0, cyc);
      expect_a("priority_band0", 0, 300);
      expect_a("priority_band2", 2, 0);
      expect_a("priority_unknown", 4, 0);

      // Enable low: nothing accumulates, timer keeps running
      en_a = 1'b0; wave_on_a = 1'b0;
      wait_pulse(0, cyc);
      wait_pulse(0, cyc);
      check("disabled_window_period", cyc, 300);
      expect_a("disabled_band0", 0, 0);
      expect_a("disabled_unknown", 4, 0);

      // Arm, classify 30 (unknown), drop enable 7 cycles later, re-arm, classify 15 (band 0)
      en_a = 1'b1;
      step(1);  manual_a = ~manual_a;
      step(30); manual_a = ~manual_a;
      step(LAT + 6); en_a = 1'b0;
      step(5);  en_a = 1'b1;
      step(25); manual_a = ~manual_a;
      step(15); manual_a = ~manual_a;
      wait_pulse(0, cyc);
      expect_a("enable_drop_unknown", 4, 37);
      expect_a("enable_drop_band0", 0, 15);
      expect_a("enable_drop_band2", 2, 0);

      // Glitched half-period-50 wave against band 2 = 45..55
      cfg_a(0, 1, 0);
      cfg_a(2, 45, 55);
      half_a = 50; glitch_on_a = 1'b1; wave_on_a = 1'b1;
      wait_pulse(0, cyc);
      wait_pulse(0, cyc);
      read_a(4, v);
`ifdef FREQUENCY_ANALYZER_GLITCH_FILTER_EN
      check("glitch_unknown", v, 0);
      expect_a("glitch_band2", 2, 300);
`else
      check("glitch_unknown_nonzero", v != 0, 1);
`endif

      // Narrow instance: saturation, then clear mid-window
      step(3);
      check("b_reset_rd_value", rd_value_b, 0);
      check("b_reset_window_count", wcount_b, 0);
      clear_b = 1'b0;
      cfg_band_b = 3'd0; cfg_low_b = 8'd1; cfg_high_b = 8'd255; cfg_we_b = 1'b1;
      step(1);
      cfg_we_b = 1'b0;
      en_b = 1'b1; wave_on_b = 1'b1;
      wait_pulse(1, cyc);
      wait_pulse(1, cyc);
      check("b_window_period", cyc, 1000);
      check("b_window_count_2", wcount_b, 2);
      expect_b("saturated_band0", 0, 255);
      expect_b("saturated_unknown", 4, 0);
      expect_b("b_rd_band_9_zero", 9, 0);
      rd_band_b = 4'd0;
      step(400);
      clear_b = 1'b1;
      step(2);
      check("b_clear_rd_value", rd_value_b, 0);
      check("b_clear_window_count", wcount_b, 0);
      check("b_clear_result_valid", valid_b, 0);
      clear_b = 1'b0;
      wait_pulse(1, cyc);
      check("b_first_pulse_after_clear", cyc, 1000);
      check("b_window_count_1", wcount_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multi_band_frequency_analyzer.md
# multi_band_frequency_analyzer

Successor to the two-band frequency analyzer. It classifies every half-period of a 1-bit input into one of BANDS runtime-programmable tick ranges and accumulates the classified durations per band over fixed measurement windows. At each window end it publishes a snapshot through an indexed read port. It sits between the sampled sensor line and the host register bank.

## Interface
- BANDS, 4, number of bands, 2..8
- COUNTER_WIDTH, 32, width of the half-period counter and all accumulators
- CLOCK_FREQUENCY, 50000000, clock rate in Hz
- DEFAULT_FREQUENCY0, 9000, band 0 reset centre frequency in Hz
- DEFAULT_FREQUENCY1, 11000, band 1 reset centre frequency in Hz
- DEFAULT_DEVIATION, 10, reset tolerance for bands 0 and 1, in percent
- WINDOW_TICKS, 50000000, measurement window length in clock cycles; must be ≥ 2
- FILTER_LENGTH, 4, glitch-filter stability length in cycles (used only with the macro)

Ports:
- clock  in  1  sole clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- sample_data  in  1  asynchronous input signal
- enable  in  1  measurement enable
- cfg_we  in  1  band-configuration write strobe
- cfg_band  in  3  band index for the write
- cfg_low  in  COUNTER_WIDTH  inclusive lower half-period bound, in ticks
- cfg_high  in  COUNTER_WIDTH  inclusive upper half-period bound, in ticks
- rd_band  in  4  readout index
- rd_value  out  COUNTER_WIDTH  registered readout value
- result_valid  out  1  one-cycle pulse when a new snapshot is available
- window_count  out  16  number of completed windows, wraps

## Operation
- Input path: sample_data passes through a 2-flop synchronizer, then a previous-value register. A detected edge is any difference between the synchronized value and the previous value.
- Half-period counter: counts clock cycles between consecutive detected edges. It saturates at all-ones.
- A square wave with a half-period of H cycles yields count = H.
- Arming: the first edge after enable rises, or after clear, only arms the counter; its count is discarded. Every later edge classifies the count and then restarts the counter from 1.
- Classification: the lowest-index band with low ≤ count ≤ high wins. If no band matches, the count goes to the unknown accumulator.
- Accumulators: one per band plus one for unknown. Addition saturates at 2^COUNTER_WIDTH−1.
- enable low: if the counter is armed and nonzero, add its value to unknown once, then clear and disarm the counter. The window timer keeps running.
- Band configuration:
  - A cfg_we write takes effect for edges detected on the following cycle.
  - Writes with cfg_band ≥ BANDS are ignored.
  - A band with low > high never matches.
- Reset values:
  - Band 0: low and high are the centre ticks T0 = CLOCK_FREQUENCY/(2·DEFAULT_FREQUENCY0), minus or plus (T0·DEFAULT_DEVIATION)/100, using integer division.
  - Band 1: the same rule applied to DEFAULT_FREQUENCY1.
  - Other bands: low = all-ones, high = 0.
- Window timer: counts 0..WINDOW_TICKS−1 continuously while clear is low. At terminal count:
  - All accumulators are copied to snapshot registers. An edge classified in the same cycle is included in the closing snapshot.
  - The live accumulators are zeroed.
  - window_count increments.
  - The in-progress half-period counter is not split.
- Readout selection by rd_band:
  - rd_band < BANDS: the band's snapshot.
  - rd_band == BANDS: the unknown snapshot.
  - rd_band > BANDS: 0.
- Outputs after reset: rd_value = 0, result_valid = 0, window_count = 0. All accumulators and snapshots reset to 0, and the counter is disarmed.

## Timing
- sample_data change to edge detection: 3 cycles, or 3 + FILTER_LENGTH cycles with the filter compiled in.
- Edge to accumulator update: 1 cycle.
- Window terminal count to snapshot update: 1 cycle. result_valid pulses in that same cycle, and the snapshot is readable on the next cycle.
- rd_band to rd_value: 1 cycle, registered.
- Simultaneous cfg_we and edge: the edge is classified with the old bounds.
- clear asserted mid-window: all state returns to reset values asynchronously, and the timer restarts at 0 after release.

## Configuration
- Macro: FREQUENCY_ANALYZER_GLITCH_FILTER_EN.
- Defined: a filter stage follows the synchronizer. The filtered output changes only after the synchronized input has held a new value for FILTER_LENGTH consecutive cycles, so pulses shorter than FILTER_LENGTH are suppressed. Edge latency becomes 3 + FILTER_LENGTH cycles.
- Undefined: no filter stage is present. FILTER_LENGTH is ignored.

## Test plan
- Reset behaviour: assert clear mid-stream with WINDOW_TICKS = 1000 → rd_value = 0, window_count = 0, and result_valid stays low for 1000 cycles after release.
- Custom band: write band 2 with low = 10, high = 20. Drive a square wave with half-period 15 and WINDOW_TICKS = 300 → from the second window on, rd_band = 2 reads 300 ± 15, rd_band = BANDS reads 0, result_valid pulses every 300 cycles.
- Unknown path and priority:
  - Half-period 40 with no band covering it → unknown reads about 300 per window.
  - Band 0 set to 10..20 overlapping band 2 → half-period 15 is credited to band 0 only.
- Enable drop: enable falls 7 cycles after an armed edge → unknown increases by 7. The next edge after enable rises only arms the counter.
- Saturation: COUNTER_WIDTH = 8 and band 0 set to 1..255 with half-period 100 over a 1000-cycle window → band 0 reads 255.
- Glitch filter: with the macro and FILTER_LENGTH = 4, inject 2-cycle glitches into a half-period-50 wave → the band for 45..55 accumulates all durations and unknown stays 0. Without the macro, unknown becomes nonzero.
